// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: sequences fetch (T0-T2), decode (T3) and execute
// (T4-T6) strobes for register-register ALU, MUL and DIV instructions.
`timescale 1ns/1ps
module control_sequencer #(
  parameter int         CNT_W   = 16,
  parameter logic [4:0] OP_HALT = 5'b11011
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Mem_ready,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             MARin,
  output logic             IncPC,
  output logic             Zin,
  output logic             ZLOout,
  output logic             ZHIout,
  output logic             PCin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             HIin,
  output logic             LOin,
  output logic [15:0]      Rin,
  output logic [15:0]      Rout,
  output logic [4:0]       ALU_op,
  output logic             Run,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instr_count
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_T0   = 4'd1;
  localparam logic [3:0] S_T1   = 4'd2;
  localparam logic [3:0] S_T1W  = 4'd3;
  localparam logic [3:0] S_T2   = 4'd4;
  localparam logic [3:0] S_T3   = 4'd5;
  localparam logic [3:0] S_T4   = 4'd6;
  localparam logic [3:0] S_T5   = 4'd7;
  localparam logic [3:0] S_T6   = 4'd8;
  localparam logic [3:0] S_HALT = 4'd9;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  logic [3:0]       state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [4:0]       op;
  logic [3:0]       ra, rb, rc;
  logic [15:0]      ra_hot, rb_hot, rc_hot;
  logic             is_alu, is_muldiv, is_halt;
  logic             unused_ir;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign is_alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
  assign is_halt   = (op == OP_HALT) && !is_alu && !is_muldiv;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_hot
      assign ra_hot[gi] = (ra == 4'(gi));
      assign rb_hot[gi] = (rb == 4'(gi));
      assign rc_hot[gi] = (rc == 4'(gi));
    end
  endgenerate

  // T1 is split so the PC update strobes fire only on the first cycle of a memory wait.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      S_IDLE: if (Start) state_next = S_T0;
      S_T0:   state_next = S_T1;
      S_T1, S_T1W: state_next = Mem_ready ? S_T2 : S_T1W;
      S_T2:   state_next = S_T3;
      S_T3: begin
        if (is_alu || is_muldiv) state_next = S_T4;
        else if (is_halt)        state_next = S_HALT;
        else                     state_next = Stop ? S_IDLE : S_T0;
      end
      S_T4:   state_next = S_T5;
      S_T5: begin
        if (is_muldiv) begin
          state_next = S_T6;
        end else begin
          count_next = count_reg + CNT_W'(1);
          state_next = Stop ? S_IDLE : S_T0;
        end
      end
      S_T6: begin
        count_next = count_reg + CNT_W'(1);
        state_next = Stop ? S_IDLE : S_T0;
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    PCout = 1'b0; MARin = 1'b0; IncPC = 1'b0; Zin = 1'b0;
    ZLOout = 1'b0; ZHIout = 1'b0; PCin = 1'b0; Read = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; Rin = '0; Rout = '0;
    ALU_op = '0; Illegal = 1'b0;
    case (state_reg)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T1W: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        if (is_alu) begin
          Rout = rb_hot; Yin = 1'b1;
        end else if (is_muldiv) begin
          Rout = ra_hot; Yin = 1'b1;
        end else if (!is_halt) begin
          Illegal = 1'b1;
        end
      end
      S_T4: begin
        Rout   = is_muldiv ? rb_hot : rc_hot;
        Zin    = 1'b1;
        ALU_op = op;
      end
      S_T5: begin
        ZLOout = 1'b1;
        if (is_muldiv) LOin = 1'b1;
        else           Rin  = ra_hot;
      end
      S_T6: begin ZHIout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

  assign Run         = (state_reg != S_IDLE) && (state_reg != S_HALT);
  assign Instr_count = count_reg;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected strobe sequences, a small
// datapath driven by the DUT strobes, directed scenarios and randomized instruction streams.
`timescale 1ns/1ps
module tb_control_sequencer;

  localparam int         CW      = 4;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  logic Clock = 1'b0, Reset = 1'b1, Start = 1'b0, Stop = 1'b0, Mem_ready = 1'b0;
  logic [31:0] IR = '0;
  logic PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin, Yin, HIin, LOin;
  logic [15:0] Rin, Rout;
  logic [4:0] ALU_op;
  logic Run, Illegal;
  logic [CW-1:0] Instr_count;

  control_sequencer #(.CNT_W(CW), .OP_HALT(OP_HALT)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Stop(Stop), .Mem_ready(Mem_ready), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .ZLOout(ZLOout), .ZHIout(ZHIout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .HIin(HIin), .LOin(LOin), .Rin(Rin), .Rout(Rout), .ALU_op(ALU_op), .Run(Run),
    .Illegal(Illegal), .Instr_count(Instr_count)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic pcout, marin, incpc, zin, zloout, zhiout, pcin, read, mdrin, mdrout, irin, yin, hiin, loin;
    logic [15:0] rin, rout;
    logic [4:0]  alu_op;
    logic        run, illegal;
  } outv_t;

  typedef struct packed {
    outv_t         exp;
    logic [CW-1:0] cnt;
    logic          rst, start, stop, mr;
    logic [31:0]   ir;
  } step_t;

  step_t q[$];
  int checks = 0, fails = 0;
  logic [CW-1:0] m_cnt = '0;
  bit m_idle = 1'b1;
  int run_cycles, pcin_cycles, incpc_cycles, read_cycles, illegal_cycles;

  // Datapath stand-in so register results can be checked; MDR reads return IR.
  logic [31:0] regs [16];
  logic [31:0] pc = '0, y = '0, hi = '0, lo = '0, bus;
  logic [63:0] z = '0;
  logic        pre_we = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always_comb begin
    bus = '0;
    if (PCout)  bus = bus | pc;
    if (ZLOout) bus = bus | z[31:0];
    if (ZHIout) bus = bus | z[63:32];
    if (MDRout) bus = bus | IR;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus = bus | regs[i];
  end

  always @(posedge Clock) begin
    if (pre_we) begin
      regs[pre_idx] <= pre_val;
    end else if (!Reset) begin
      if (Yin)  y  <= bus;
      if (HIin) hi <= bus;
      if (LOin) lo <= bus;
      if (PCin) pc <= bus;
      if (Zin) begin
        if (IncPC) z <= {32'b0, bus + 32'd1};
        else case (ALU_op)
          OP_ADD: z <= {32'b0, y + bus};
          OP_SUB: z <= {32'b0, y - bus};
          OP_AND: z <= {32'b0, y & bus};
          OP_OR:  z <= {32'b0, y | bus};
          OP_MUL: z <= {32'b0, y} * {32'b0, bus};
          OP_DIV: z <= (bus == 0) ? 64'b0 : {y % bus, y / bus};
          default: z <= 64'b0;
        endcase
      end
      for (int i = 0; i < 16; i++) if (Rin[i]) regs[i] <= bus;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  function automatic void push(input outv_t v, input bit boundary, input bit stop_end,
                               input logic [31:0] ir, input bit mr, input bit rst);
    step_t s;
    s.exp   = v;
    s.cnt   = m_cnt;
    s.rst   = rst;
    s.start = 1'($urandom);
    s.stop  = boundary ? stop_end : 1'($urandom);
    s.mr    = mr;
    s.ir    = ir;
    q.push_back(s);
  endfunction

  function automatic outv_t running();
    outv_t v;
    v = '0;
    v.run = 1'b1;
    return v;
  endfunction

  // Appends the expected cycle-by-cycle outputs of one instruction (or of its truncation).
  task automatic add_instr(input logic [31:0] ir, input int waits, input bit stop_end,
                           input int idle_n, input bit rst_t4);
    outv_t v;
    logic [4:0] op;
    bit alu, muldiv, halt;
    op     = ir[31:27];
    alu    = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    muldiv = (op == OP_MUL) || (op == OP_DIV);
    halt   = (op == OP_HALT) && !alu && !muldiv;
    if (m_idle) begin
      for (int i = 0; i <= idle_n; i++) begin
        push('0, 1'b0, 1'b0, ir, 1'($urandom), 1'b0);
        q[q.size()-1].start = (i == idle_n);
      end
      m_idle = 1'b0;
    end
    v = running(); v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1;
    push(v, 1'b0, 1'b0, ir, 1'($urandom), 1'b0);
    v = running(); v.zloout = 1; v.pcin = 1; v.read = 1; v.mdrin = 1;
    push(v, 1'b0, 1'b0, ir, waits == 0, 1'b0);
    for (int i = 1; i <= waits; i++) begin
      v = running(); v.read = 1; v.mdrin = 1;
      push(v, 1'b0, 1'b0, ir, i == waits, 1'b0);
    end
    v = running(); v.mdrout = 1; v.irin = 1;
    push(v, 1'b0, 1'b0, ir, 1'($urandom), 1'b0);
    v = running();
    if (alu)         begin v.rout = 16'd1 << ir[22:19]; v.yin = 1; end
    else if (muldiv) begin v.rout = 16'd1 << ir[26:23]; v.yin = 1; end
    else if (!halt)  v.illegal = 1;
    push(v, !(alu || muldiv || halt), stop_end, ir, 1'($urandom), 1'b0);
    if (halt) begin
      for (int i = 0; i < 4; i++) push('0, 1'b0, 1'b0, ir, 1'($urandom), 1'b0);
      return;
    end
    if (!(alu || muldiv)) begin
      m_idle = stop_end;
      return;
    end
    v = running(); v.zin = 1; v.alu_op = op;
    v.rout = 16'd1 << (muldiv ? ir[22:19] : ir[18:15]);
    push(v, 1'b0, 1'b0, ir, 1'($urandom), rst_t4);
    if (rst_t4) begin
      m_cnt = '0;
      push('0, 1'b0, 1'b0, ir, 1'($urandom), 1'b1);
      push('0, 1'b0, 1'b0, ir, 1'($urandom), 1'b1);
      m_idle = 1'b1;
      return;
    end
    v = running(); v.zloout = 1;
    if (muldiv) v.loin = 1;
    else        v.rin = 16'd1 << ir[26:23];
    push(v, alu, stop_end, ir, 1'($urandom), 1'b0);
    if (alu) m_cnt = m_cnt + 1'b1;
    if (muldiv) begin
      v = running(); v.zhiout = 1; v.hiin = 1;
      push(v, 1'b1, stop_end, ir, 1'($urandom), 1'b0);
      m_cnt = m_cnt + 1'b1;
    end
    m_idle = stop_end;
  endtask

  // Reset applied while halted or idle: those states show all-zero outputs.
  task automatic add_reset(input int n);
    for (int i = 0; i < n; i++) begin
      push('0, 1'b0, 1'b0, IR, 1'($urandom), 1'b1);
      m_cnt = '0;
    end
    m_idle = 1'b1;
  endtask

  task automatic run_queue();
    step_t e;
    outv_t act;
    run_cycles = 0; pcin_cycles = 0; incpc_cycles = 0; read_cycles = 0; illegal_cycles = 0;
    while (q.size() > 0) begin
      @(negedge Clock);
      e = q.pop_front();
      Reset = e.rst; Start = e.start; Stop = e.stop; Mem_ready = e.mr; IR = e.ir;
      #1;
      act = '{PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin, Read, MDRin, MDRout, IRin,
              Yin, HIin, LOin, Rin, Rout, ALU_op, Run, Illegal};
      check("strobes", 64'(act), 64'(e.exp));
      check("instr_count", 64'(Instr_count), 64'(e.cnt));
      if (Run)     run_cycles++;
      if (PCin)    pcin_cycles++;
      if (IncPC)   incpc_cycles++;
      if (Read)    read_cycles++;
      if (Illegal) illegal_cycles++;
    end
    @(posedge Clock);
    #1;
    Reset = 1'b0; Start = 1'b0; Stop = 1'b0; Mem_ready = 1'b0;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    @(negedge Clock);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge Clock);
    #1;
    pre_we = 1'b0;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'b0};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] op;
    logic [4:0] legal [6];
    legal = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV};
    for (int i = 0; i < 16; i++) preload(4'(i), 32'(i * 3 + 1));
    preload(4'd2, 32'h14);
    preload(4'd3, 32'h12);
    preload(4'd4, 32'd7);
    preload(4'd5, 32'd6);

    // ADD R1,R2,R3; Stop held at the boundary so it completes, then idles.
    add_instr(32'h18918000, 0, 1'b1, 2, 1'b0);
    run_queue();
    check("add_r1", 64'(regs[1]), 64'h26);
    check("add_count", 64'(Instr_count), 64'd1);
    check("add_cycles", 64'(run_cycles), 64'd6);
    check("add_idle_run", 64'(Run), 64'd0);

    // SUB with a 4-cycle memory wait.
    add_instr(mk(OP_SUB, 4'd6, 4'd7, 4'd8), 4, 1'b1, 1, 1'b0);
    run_queue();
    check("wait_pcin", 64'(pcin_cycles), 64'd1);
    check("wait_incpc", 64'(incpc_cycles), 64'd1);
    check("wait_read", 64'(read_cycles), 64'd5);
    check("wait_cycles", 64'(run_cycles), 64'd10);
    check("sub_count", 64'(Instr_count), 64'd2);

    // MUL R4(7) x R5(6).
    add_instr(mk(OP_MUL, 4'd4, 4'd5, 4'd0), 0, 1'b1, 1, 1'b0);
    run_queue();
    check("mul_lo", 64'(lo), 64'd42);
    check("mul_hi", 64'(hi), 64'd0);
    check("mul_cycles", 64'(run_cycles), 64'd7);
    check("mul_count", 64'(Instr_count), 64'd3);

    // Undecoded opcode skipped, then HALT, then reset out of HALT.
    add_instr(mk(5'b01010, 4'd1, 4'd2, 4'd3), 0, 1'b0, 1, 1'b0);
    add_instr(mk(OP_HALT, 4'd0, 4'd0, 4'd0), 1, 1'b0, 1, 1'b0);
    add_reset(2);
    run_queue();
    check("illegal_pulses", 64'(illegal_cycles), 64'd1);
    check("halt_reset_count", 64'(Instr_count), 64'd0);

    // Randomized instruction stream; the counter is narrow so it wraps.
    for (int n = 0; n < 80; n++) begin
      int pick;
      pick = $urandom_range(0, 15);
      if (pick < 12) op = legal[pick % 6];
      else if (pick < 15) begin
        op = 5'($urandom);
        while (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MUL, OP_DIV, OP_HALT}) op = 5'($urandom);
      end else op = OP_HALT;
      add_instr(mk(op, 4'($urandom), 4'($urandom), 4'($urandom)), $urandom_range(0, 3),
                (n == 79) || ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b0);
      if (op == OP_HALT) add_reset($urandom_range(1, 3));
      if (n == 79 && !m_idle) add_reset(1);
    end
    run_queue();

    // Reset held three clocks starting mid-T4 of an ADD.
    add_instr(mk(OP_ADD, 4'd9, 4'd10, 4'd11), 0, 1'b0, 1, 1'b0);
    add_instr(mk(OP_ADD, 4'd9, 4'd10, 4'd11), 1, 1'b0, 1, 1'b1);
    add_instr(32'h18918000, 0, 1'b1, 1, 1'b0);
    run_queue();
    check("post_reset_count", 64'(Instr_count), 64'd1);
    check("post_reset_run", 64'(Run), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
